prach_hb_dec_tdm: RTL and testbench

Parametrised, time-multiplexed half-band decimate-by-2 stage for the PRACH DDC chain. It takes a TDM stream of NCH complex channels and keeps a per-channel delay line and decimation phase. Each channel is filtered with a symmetric half-band FIR and emits one complex output per two inputs. It generalises the fixed-geometry HB stages with configurable width, tap count and channel count, a runtime bypass mode and channel-sequence checking.

---
 rtl/prach_hb_dec_tdm.sv | 200 ++++++++++++++++++++
 tb/tb_prach_hb_dec_tdm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prach_hb_dec_tdm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : prach_hb_dec_tdm                                            |
// | TDM half-band decimate-by-2 FIR for NCH complex channels. Keeps a    |
// | delay line and decimation phase per channel, offers a bypass mode    |
// | (centre tap only, unscaled) and checks the incoming channel order.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module prach_hb_dec_tdm #(
  parameter int              DW      = 16,
  parameter int              NCH     = 8,
  parameter int              M       = 3,
  parameter int              CW      = 18,
  parameter logic [M*CW-1:0] HB_COEF = {-18'sd1536, 18'sd9728, 18'sd24576}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_dr,
  input  logic [DW-1:0] din_di,
  input  logic          din_dv,
  input  logic [7:0]    din_chn,
  input  logic          sync_in,
  input  logic          ctrl_bypass,
  output logic [DW-1:0] dout_dr,
  output logic [DW-1:0] dout_di,
  output logic          dout_dv,
  output logic [7:0]    dout_chn,
  output logic          sync_out,
  output logic          err_seq
);
  localparam int NTAP = 4*M - 1;
  localparam int CTR  = 2*M - 1;
  localparam int CI   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = DW + 1;
  localparam int PRW  = PW + CW;
  localparam int AW   = PRW + $clog2(M + 1) + 1;
  localparam logic signed [AW-1:0] c_HALF = {{(AW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};
  localparam logic signed [AW-1:0] c_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] c_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Per-channel state
  logic signed [DW-1:0] dl_re_q [NCH][NTAP];
  logic signed [DW-1:0] dl_im_q [NCH][NTAP];
  logic [NCH-1:0]       ph_q;
  logic [7:0]           ec_q, ec_d;
  logic                 err_q;

  // Pipeline registers
  logic                 v1_q, v2_q, v3_q, byp1_q, byp2_q, byp3_q;
  logic [7:0]           chn1_q, chn2_q, chn3_q;
  logic signed [PW-1:0] pre1_re_q [M];
  logic signed [PW-1:0] pre1_im_q [M];
  logic signed [DW-1:0] ctr1_re_q, ctr1_im_q, ctr2_re_q, ctr2_im_q, ctr3_re_q, ctr3_im_q;
  logic signed [PRW-1:0] prod2_re_q [M];
  logic signed [PRW-1:0] prod2_im_q [M];
  logic signed [AW-1:0] acc3_re_q, acc3_im_q, acc_re_d, acc_im_d;
  logic [DW-1:0]        dout_dr_q, dout_di_q;
  logic                 dout_dv_q;
  logic [7:0]           dout_chn_q;
  logic [3:0]           sync_q;

  // Combinational helpers
  logic signed [CW-1:0] w_coef [M];
  logic signed [DW-1:0] w_win_re [NTAP];
  logic signed [DW-1:0] w_win_im [NTAP];
  logic [CI-1:0]        w_c;
  logic                 w_in_rng, w_acc, w_ph_old, w_launch;
  logic [7:0]           w_ec_base;

  // First listed coefficient (MSB end) belongs to the outermost tap pair
  for (genvar k = 0; k < M; k++) begin : g_coef
    assign w_coef[k] = HB_COEF[(M-1-k)*CW +: CW];
  end

  // Round half up, drop CW-1 fraction bits, clamp to the output range
  function automatic logic [DW-1:0] rnd_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    r = (a + c_HALF) >>> (CW - 1);
    if (r > c_MAX)      rnd_sat = c_MAX[DW-1:0];
    else if (r < c_MIN) rnd_sat = c_MIN[DW-1:0];
    else                rnd_sat = r[DW-1:0];
  endfunction

  // Updated window for the addressed channel, phase and sequence decode
  always_comb begin
    w_c       = din_chn[CI-1:0];
    w_in_rng  = ({1'b0, din_chn} < 9'(NCH));
    w_acc     = din_dv & w_in_rng;
    w_ph_old  = sync_in ? 1'b0 : ph_q[w_c];
    w_launch  = w_acc & w_ph_old;
    w_ec_base = sync_in ? 8'd0 : ec_q;
    ec_d      = 8'(({1'b0, din_chn} + 9'd1) % 9'(NCH));
    w_win_re[0] = $signed(din_dr);
    w_win_im[0] = $signed(din_di);
    for (int k = 1; k < NTAP; k++) begin
      w_win_re[k] = dl_re_q[w_c][k-1];
      w_win_im[k] = dl_im_q[w_c][k-1];
    end
  end

  // Delay lines, phase bits, expected-channel counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q  <= '0;
      ec_q  <= '0;
      err_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < NTAP; k++) begin
          dl_re_q[c][k] <= '0;
          dl_im_q[c][k] <= '0;
        end
      end
    end else begin
      if (sync_in) begin
        ph_q <= '0;
        ec_q <= '0;
      end
      if (w_acc) begin
        ph_q[w_c] <= ~w_ph_old;
        for (int k = 0; k < NTAP; k++) begin
          dl_re_q[w_c][k] <= w_win_re[k];
          dl_im_q[w_c][k] <= w_win_im[k];
        end
      end
      if (din_dv) begin
        ec_q <= ec_d;
        if (din_chn != w_ec_base) err_q <= 1'b1;
      end
    end
  end

  // Adder tree input: centre tap scaled by 0.5 plus all side products
  always_comb begin
    acc_re_d = AW'(ctr2_re_q) <<< (CW - 2);
    acc_im_d = AW'(ctr2_im_q) <<< (CW - 2);
    for (int k = 0; k < M; k++) begin
      acc_re_d = acc_re_d + AW'(prod2_re_q[k]);
      acc_im_d = acc_im_d + AW'(prod2_im_q[k]);
    end
  end

  // Four-stage datapath: pre-add, multiply, sum, round/saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      dout_dv_q  <= 1'b0;
      dout_dr_q  <= '0;
      dout_di_q  <= '0;
      dout_chn_q <= '0;
    end else begin
      v1_q      <= w_launch;
      chn1_q    <= din_chn;
      byp1_q    <= ctrl_bypass;
      ctr1_re_q <= w_win_re[CTR];
      ctr1_im_q <= w_win_im[CTR];
      for (int k = 0; k < M; k++) begin
        pre1_re_q[k] <= PW'(w_win_re[2*k]) + PW'(w_win_re[NTAP-1-2*k]);
        pre1_im_q[k] <= PW'(w_win_im[2*k]) + PW'(w_win_im[NTAP-1-2*k]);
      end
      v2_q      <= v1_q;
      chn2_q    <= chn1_q;
      byp2_q    <= byp1_q;
      ctr2_re_q <= ctr1_re_q;
      ctr2_im_q <= ctr1_im_q;
      for (int k = 0; k < M; k++) begin
        prod2_re_q[k] <= PRW'(pre1_re_q[k]) * PRW'(w_coef[k]);
        prod2_im_q[k] <= PRW'(pre1_im_q[k]) * PRW'(w_coef[k]);
      end
      v3_q      <= v2_q;
      chn3_q    <= chn2_q;
      byp3_q    <= byp2_q;
      ctr3_re_q <= ctr2_re_q;
      ctr3_im_q <= ctr2_im_q;
      acc3_re_q <= acc_re_d;
      acc3_im_q <= acc_im_d;
      dout_dv_q <= v3_q;
      if (v3_q) begin
        dout_chn_q <= chn3_q;
        dout_dr_q  <= byp3_q ? ctr3_re_q : rnd_sat(acc3_re_q);
        dout_di_q  <= byp3_q ? ctr3_im_q : rnd_sat(acc3_im_q);
      end
    end
  end

  // Frame sync travels alongside the datapath latency
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[2:0], sync_in};
  end

  assign dout_dr  = dout_dr_q;
  assign dout_di  = dout_di_q;
  assign dout_dv  = dout_dv_q;
  assign dout_chn = dout_chn_q;
  assign sync_out = sync_q[3];
  assign err_seq  = err_q;
endmodule
`default_nettype wire

// File: tb/tb_prach_hb_dec_tdm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_prach_hb_dec_tdm                                         |
// | Scoreboard bench for prach_hb_dec_tdm: directed vectors push         |
// | hand-computed outputs; a monitor pops and compares on dout_dv.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_prach_hb_dec_tdm;
  localparam int NCH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din_dr = '0;
  logic [15:0] din_di = '0;
  logic        din_dv = 1'b0;
  logic [7:0]  din_chn = '0;
  logic        sync_in = 1'b0;
  logic        ctrl_bypass = 1'b0;
  logic [15:0] dout_dr, dout_di;
  logic        dout_dv, sync_out, err_seq;
  logic [7:0]  dout_chn;

  always #5 clk = ~clk;

  prach_hb_dec_tdm dut (
    .clk(clk), .rst(rst),
    .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv), .din_chn(din_chn),
    .sync_in(sync_in), .ctrl_bypass(ctrl_bypass),
    .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .dout_chn(dout_chn),
    .sync_out(sync_out), .err_seq(err_seq)
  );

  typedef struct {
    int chn;
    int cyc;
    bit care;
    int re;
    int im;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         ph[NCH];
  logic [3:0] shist = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic clear_ph();
    for (int i = 0; i < NCH; i++) ph[i] = 1'b0;
  endtask

  // One input sample; pushes the expected output when this sample launches one
  task automatic send(input int c, input int re, input int im,
                      input bit care, input int ere, input int eim);
    bit pold;
    din_dv  = 1'b1;
    din_chn = 8'(c);
    din_dr  = 16'(re);
    din_di  = 16'(im);
    if (c < NCH) begin
      pold = sync_in ? 1'b0 : ph[c];
      if (sync_in) clear_ph();
      if (pold) sbq.push_back('{c, cyc + 4, care, ere, eim});
      ph[c] = !pold;
    end else if (sync_in) begin
      clear_ph();
    end
    @(posedge clk); #1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (sync_in) clear_ph();
      @(posedge clk); #1;
      sync_in = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    clear_ph();
  endtask

  // ch3 impulse on phase 0, ch4 impulse on phase 1: together they expose
  // every tap of the filter (centre via ch3, side taps via ch4)
  task automatic impulse_run(input bit byp);
    int lut[6];
    int v;
    int e;
    lut = '{-192, 1216, 3072, 3072, 1216, -192};
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < NCH; c++) begin
        v = ((r == 0 && c == 3) || (r == 1 && c == 4)) ? 16384 : 0;
        e = 0;
        if (r % 2 == 1) begin
          if (c == 3 && r == 5) e = byp ? 16384 : 8192;
          if (c == 4 && !byp && (r - 1) <= 10) e = lut[(r-1)/2];
        end
        send(c, v, 0, 1'b1, e, 0);
      end
    end
  endtask

  // Cycle counter used to verify the fixed output latency
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor and sync_out alignment check
  initial forever begin
    @(negedge clk);
    if (dout_dv === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got dout_dv=1 chn=%0d, required no output", dout_chn);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_chn", int'(dout_chn), mon_e.chn);
        chk("out_latency_cycle", cyc, mon_e.cyc);
        if (mon_e.care) begin
          chk("out_re", int'($signed(dout_dr)), mon_e.re);
          chk("out_im", int'($signed(dout_di)), mon_e.im);
        end
      end
    end
    if (sync_out === 1'b1 || shist[3]) chk("sync_out_delay", int'(sync_out), int'(shist[3]));
    shist = {shist[2:0], sync_in};
  end

  int iv[12];
  int qv[12];

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_dv", int'(dout_dv), 0);
    chk("rst_dout_dr", int'(dout_dr), 0);
    chk("rst_dout_chn", int'(dout_chn), 0);
    chk("rst_err_seq", int'(err_seq), 0);
    chk("rst_sync_out", int'(sync_out), 0);
    rst = 1'b0;

    // Impulse response
    impulse_run(1'b0);
    chk("impulse_err_seq", int'(err_seq), 0);

    // DC gain: exact once the whole window holds the DC level
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < NCH; c++)
        send(c, 10000, 10000, r >= 11, 10000, 10000);

    // Rounding: only odd samples nonzero, so only the centre tap contributes
    do_reset(2);
    send(0,  1, -1, 1'b1, 0, 0);
    send(0,  0,  0, 1'b1, 0, 0);
    send(0, -1,  1, 1'b1, 0, 0);
    send(0,  0,  0, 1'b1, 0, 0);
    send(0,  3, -3, 1'b1, 0, 0);
    send(0,  0,  0, 1'b1, 1, 0);
    send(0, -3,  3, 1'b1, 0, 0);
    send(0,  0,  0, 1'b1, 0, 1);
    send(0,  0,  0, 1'b1, 0, 0);
    send(0,  0,  0, 1'b1, 2, -1);
    send(0,  0,  0, 1'b1, 0, 0);
    send(0,  0,  0, 1'b1, -1, 2);

    // Saturation: worst-case window, I saturates high, Q saturates low
    iv = '{0, -32768, 0, 32767, 0, 32767, 32767, 32767, 0, 32767, 0, -32768};
    qv = '{0, 32767, 0, -32768, 0, -32768, -32768, -32768, 0, -32768, 0, 32767};
    for (int i = 0; i < 12; i++)
      send(1, iv[i], qv[i], i == 11, 32767, -32768);

    // Sequence error
    do_reset(2);
    chk("seq_err_after_rst", int'(err_seq), 0);
    send(0, 0, 0, 1'b1, 0, 0);
    send(1, 0, 0, 1'b1, 0, 0);
    send(2, 0, 0, 1'b1, 0, 0);
    chk("seq_err_in_order", int'(err_seq), 0);
    send(5, 0, 0, 1'b1, 0, 0);
    chk("seq_err_rise", int'(err_seq), 1);
    send(6, 0, 0, 1'b1, 0, 0);
    send(7, 0, 0, 1'b1, 0, 0);
    send(0, 0, 0, 1'b1, 0, 0);
    chk("seq_err_sticky", int'(err_seq), 1);

    // Sync mid-round, then bypass impulse
    send(1, 0, 0, 1'b1, 0, 0);
    send(2, 0, 0, 1'b1, 0, 0);
    send(3, 0, 0, 1'b1, 0, 0);
    sync_in = 1'b1;
    idle(1);
    idle(2);
    chk("sync_out_early", int'(sync_out), 0);
    idle(1);
    chk("sync_out_at_4", int'(sync_out), 1);
    ctrl_bypass = 1'b1;
    impulse_run(1'b1);
    ctrl_bypass = 1'b0;

    // Reset mid-stream
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NCH; c++)
        if (r < 3 || c < 5) send(c, 10000, -10000, 1'b0, 0, 0);
    do_reset(1);
    chk("midrst_dout_dv", int'(dout_dv), 0);
    chk("midrst_dout_dr", int'(dout_dr), 0);
    chk("midrst_dout_di", int'(dout_di), 0);
    chk("midrst_dout_chn", int'(dout_chn), 0);
    chk("midrst_err_seq", int'(err_seq), 0);
    idle(4);

    // Out-of-range channel is dropped but flagged
    send(200, 16384, 16384, 1'b1, 0, 0);
    chk("bad_chn_err", int'(err_seq), 1);
    impulse_run(1'b0);

    idle(10);
    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
